// File: rtl/list_sum_engine.sv
// list_sum_engine
//   Walks a singly linked list in word-addressed memory, starting at a head
//   pointer. It adds every node value into a wide sum and counts the nodes.
//   A node at address p holds its value in mem[p] and its next pointer in
//   mem[p+1]. Pointer value 0 terminates the list.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   start       level; a run begins when start is high in IDLE
//   head_addr   list head, sampled when a run is accepted
//   mem_req     one-cycle read request
//   mem_addr    read address, valid while mem_req is high
//   mem_rvalid  read data valid; the memory returns exactly one per request
//   mem_rdata   read data
//   busy        high from run acceptance until DONE is entered
//   done        high while in DONE; sum, count and flags are held
//   sum         running or final sum, modulo 2^SUM_W
//   count       number of nodes accumulated
//   overflow    sticky for the run; set when the sum wrapped
//   err_len     set when the walk was cut short at MAX_NODES nodes
//
// Every output is either a flop or a decode of the state and pointer flops,
// so no combinational path runs from any input to any output.
module list_sum_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int SUM_W     = 24,
  parameter int MAX_NODES = 255,
  parameter int CNT_W     = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              err_len
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ_VAL   = 3'd1;
  localparam logic [2:0] S_WAIT_VAL  = 3'd2;
  localparam logic [2:0] S_REQ_NEXT  = 3'd3;
  localparam logic [2:0] S_WAIT_NEXT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] ptr_q,      ptr_d;
  logic [SUM_W-1:0]  sum_q,      sum_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic              err_len_q,  err_len_d;

  // One extra bit captures the carry out of the top sum bit.
  logic [SUM_W:0]    sum_ext;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    err_len_d  = err_len_q;
    sum_ext    = {1'b0, sum_q} + (SUM_W + 1)'(mem_rdata);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          err_len_d  = 1'b0;
          ptr_d      = head_addr;
          state_d    = (head_addr == '0) ? S_DONE : S_REQ_VAL;
        end
      end

      S_REQ_VAL: state_d = S_WAIT_VAL;

      S_WAIT_VAL: begin
        if (mem_rvalid) begin
          sum_d      = sum_ext[SUM_W-1:0];
          overflow_d = overflow_q | sum_ext[SUM_W];
          count_d    = count_q + CNT_W'(1);
          state_d    = S_REQ_NEXT;
        end
      end

      S_REQ_NEXT: state_d = S_WAIT_NEXT;

      S_WAIT_NEXT: begin
        if (mem_rvalid) begin
          // The terminator test uses the full word; only the low ADDR_W
          // bits are kept when the word is followed as a pointer.
          if (mem_rdata == '0) begin
            state_d = S_DONE;
          end else if (count_q == CNT_W'(MAX_NODES)) begin
            err_len_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            ptr_d   = mem_rdata[ADDR_W-1:0];
            state_d = S_REQ_VAL;
          end
        end
      end

      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_len_q  <= err_len_d;
    end
  end

  // The next-pointer word sits one above the value word and wraps with the
  // address width.
  always_comb begin
    mem_req  = (state_q == S_REQ_VAL) || (state_q == S_REQ_NEXT);
    mem_addr = '0;
    if (state_q == S_REQ_VAL)  mem_addr = ptr_q;
    if (state_q == S_REQ_NEXT) mem_addr = ptr_q + ADDR_W'(1);
    busy     = (state_q == S_REQ_VAL)  || (state_q == S_WAIT_VAL) ||
               (state_q == S_REQ_NEXT) || (state_q == S_WAIT_NEXT);
    done     = (state_q == S_DONE);
    sum      = sum_q;
    count    = count_q;
    overflow = overflow_q;
    err_len  = err_len_q;
  end

endmodule
